// File: rtl/aes_dec_pkg.sv
// -----------------------------------------------------------------------------
// aes_dec_pkg
// Shared definitions for the AES decryption round scheduler:
//   state_t        one-hot FSM state encoding (also exported for debug)
//   MEM_SEL_*      codes naming the current owner of the statemt ports
//   NB_128/192/256 legal total round counts
//   nb_is_valid()  true when a round count is one of the legal values
// -----------------------------------------------------------------------------
package aes_dec_pkg;

  typedef enum logic [5:0] {
    ST_IDLE     = 6'b000001,
    ST_ARK_INIT = 6'b000010,
    ST_ISB      = 6'b000100,
    ST_ARK      = 6'b001000,
    ST_IMC      = 6'b010000,
    ST_DONE     = 6'b100000
  } state_t;

  localparam logic [1:0] MEM_SEL_ARK  = 2'd0;
  localparam logic [1:0] MEM_SEL_ISB  = 2'd1;
  localparam logic [1:0] MEM_SEL_IMC  = 2'd2;
  localparam logic [1:0] MEM_SEL_NONE = 2'd3;

  localparam int unsigned NB_128 = 10;
  localparam int unsigned NB_192 = 12;
  localparam int unsigned NB_256 = 14;

  function automatic logic nb_is_valid(input int unsigned n);
    return (n == NB_128) || (n == NB_192) || (n == NB_256);
  endfunction

endpackage

// File: rtl/aes_dec_round_sched_if.sv
// -----------------------------------------------------------------------------
// aes_dec_round_sched_if
// Bundles the control/status and engine handshake signals of the scheduler.
//   ap_start/ap_done/ap_idle/ap_ready  HLS-style block control
//   nb, err, round                     round count in, error flag, counter out
//   ark_*/isb_*/imc_*                  start/done pairs to the three engines
//   mem_sel                            owner of the shared statemt ports
//   dbg_state                          current FSM state, for observation
//
// Handshake: each *_start is a level that stays high for every cycle the FSM
// sits in the owning state. The engine answers with *_done; the FSM leaves the
// state on the rising edge where start and done are both high. A done seen
// outside the owning state is ignored; done may already be high in the first
// cycle of start, which gives a one-cycle invocation.
// -----------------------------------------------------------------------------
interface aes_dec_round_sched_if #(parameter int NB_W = 4);
  import aes_dec_pkg::*;

  logic            ap_start;
  logic            ap_done;
  logic            ap_idle;
  logic            ap_ready;
  logic [NB_W-1:0] nb;
  logic            err;
  logic            ark_start;
  logic            ark_done;
  logic [4:0]      ark_n;
  logic            isb_start;
  logic            isb_done;
  logic            imc_start;
  logic            imc_done;
  logic [1:0]      mem_sel;
  logic [NB_W-1:0] round;
  state_t          dbg_state;

  modport slave (
    input  ap_start, nb, ark_done, isb_done, imc_done,
    output ap_done, ap_idle, ap_ready, err, ark_start, ark_n,
           isb_start, imc_start, mem_sel, round, dbg_state
  );

  modport master (
    output ap_start, nb, ark_done, isb_done, imc_done,
    input  ap_done, ap_idle, ap_ready, err, ark_start, ark_n,
           isb_start, imc_start, mem_sel, round, dbg_state
  );

endinterface

// File: rtl/aes_dec_round_ctr.sv
// -----------------------------------------------------------------------------
// aes_dec_round_ctr
// Round counter r: loadable, decrementing, with a zero flag.
//   i_clk, i_rst   clock, asynchronous active-high reset (count -> 0)
//   i_load         load i_load_val (has priority over i_dec)
//   i_dec          decrement by one
//   o_count        current count
//   o_zero         count == 0
// -----------------------------------------------------------------------------
module aes_dec_round_ctr #(
  parameter int NB_W = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_load,
  input  logic [NB_W-1:0] i_load_val,
  input  logic            i_dec,
  output logic [NB_W-1:0] o_count,
  output logic            o_zero
);

  logic [NB_W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec) begin
      r_count <= r_count - NB_W'(1);
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule

// File: rtl/aes_dec_round_sched.sv
// -----------------------------------------------------------------------------
// aes_dec_round_sched
// Sequences the AES inverse cipher: one initial AddRoundKey with key nb, then
// nb rounds of InvShiftRows+InvSubBytes -> AddRoundKey(r) -> InvMixColumns,
// the last round skipping InvMixColumns.
//   ap_clk   clock, rising edge
//   ap_rst   asynchronous active-high reset
//   bus      aes_dec_round_sched_if.slave (control, status, engine handshakes)
// -----------------------------------------------------------------------------
module aes_dec_round_sched
  import aes_dec_pkg::*;
#(
  parameter int NB_W = 4
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  aes_dec_round_sched_if.slave  bus
);

  state_t          r_state;
  logic [NB_W-1:0] r_nb;
  logic            r_err;

  logic            w_ctr_load;
  logic            w_ctr_dec;
  logic            w_ctr_zero;
  logic [NB_W-1:0] w_round;
  logic [4:0]      w_ark_n;
  logic [1:0]      w_mem_sel;

  // Counter is loaded with nb-1 as the initial AddRoundKey completes and
  // stepped down each time InvMixColumns completes.
  assign w_ctr_load = (r_state == ST_ARK_INIT) && bus.ark_done;
  assign w_ctr_dec  = (r_state == ST_IMC) && bus.imc_done;

  aes_dec_round_ctr #(.NB_W(NB_W)) u_round_ctr (
    .i_clk      (ap_clk),
    .i_rst      (ap_rst),
    .i_load     (w_ctr_load),
    .i_load_val (r_nb - NB_W'(1)),
    .i_dec      (w_ctr_dec),
    .o_count    (w_round),
    .o_zero     (w_ctr_zero)
  );

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_state <= ST_IDLE;
      r_nb    <= '0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (bus.ap_start) begin
            r_nb <= bus.nb;
            if (nb_is_valid(32'(bus.nb))) begin
              r_err   <= 1'b0;
              r_state <= ST_ARK_INIT;
            end else begin
              // Invalid round count: report through DONE without any engine.
              r_err   <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
        ST_ARK_INIT: if (bus.ark_done) r_state <= ST_ISB;
        ST_ISB:      if (bus.isb_done) r_state <= ST_ARK;
        ST_ARK:      if (bus.ark_done) r_state <= w_ctr_zero ? ST_DONE : ST_IMC;
        ST_IMC:      if (bus.imc_done) r_state <= ST_ISB;
        ST_DONE:     r_state <= ST_IDLE;
        default:     r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_ark_n   = 5'd0;
    w_mem_sel = MEM_SEL_NONE;
    case (r_state)
      ST_ARK_INIT: begin w_ark_n = 5'(r_nb);    w_mem_sel = MEM_SEL_ARK; end
      ST_ARK:      begin w_ark_n = 5'(w_round); w_mem_sel = MEM_SEL_ARK; end
      ST_ISB:      w_mem_sel = MEM_SEL_ISB;
      ST_IMC:      w_mem_sel = MEM_SEL_IMC;
      default:     ;
    endcase
  end

  assign bus.ark_start = (r_state == ST_ARK_INIT) || (r_state == ST_ARK);
  assign bus.isb_start = (r_state == ST_ISB);
  assign bus.imc_start = (r_state == ST_IMC);
  assign bus.ark_n     = w_ark_n;
  assign bus.mem_sel   = w_mem_sel;
  assign bus.ap_done   = (r_state == ST_DONE);
  assign bus.ap_ready  = (r_state == ST_DONE);
  assign bus.ap_idle   = (r_state == ST_IDLE) && !bus.ap_start;
  assign bus.err       = r_err;
  assign bus.round     = w_round;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_aes_dec_round_sched.sv
// -----------------------------------------------------------------------------
// tb_aes_dec_round_sched
// Self-checking bench for aes_dec_round_sched: engine responder with
// configurable done delay, ark_n scoreboard, table of pass vectors, and
// hand-written sequences for ignored done, mid-pass reset and back-to-back.
// -----------------------------------------------------------------------------
module tb_aes_dec_round_sched;
  import aes_dec_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_dec_round_sched_if #(.NB_W(4)) bus ();

  aes_dec_round_sched #(.NB_W(4)) dut (
    .ap_clk (clk),
    .ap_rst (rst),
    .bus    (bus)
  );

  // ---------------- responder configuration and done muxing ----------------
  bit manual  = 1'b1;
  bit tie_all = 1'b0;
  int dly     = 0;
  logic man_ark = 1'b0, man_isb = 1'b0, man_imc = 1'b0;
  logic auto_ark = 1'b0, auto_isb = 1'b0, auto_imc = 1'b0;

  assign bus.ark_done = manual ? man_ark : auto_ark;
  assign bus.isb_done = manual ? man_isb : auto_isb;
  assign bus.imc_done = manual ? man_imc : auto_imc;

  // ---------------- scoreboard state ----------------
  logic [4:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  int ark_seen = 0, isb_seen = 0, imc_seen = 0;
  int ark_bad = 0, ark_extra = 0, cyc_err = 0, hold_err = 0;
  int ark_cnt = 0, isb_cnt = 0, imc_cnt = 0;
  bit ark_pend = 0, isb_pend = 0, imc_pend = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Responder + monitor: decide done for the coming edge, then record what
  // the DUT shows this cycle.
  always @(negedge clk) begin
    logic [1:0] e_sel;
    logic e_ark, e_isb, e_imc;
    if (!manual && !rst) begin
      if (tie_all) begin
        auto_ark = 1'b1; auto_isb = 1'b1; auto_imc = 1'b1;
      end else begin
        if (bus.ark_start) begin auto_ark = (ark_cnt >= dly); ark_cnt++; end
        else begin auto_ark = 1'b0; ark_cnt = 0; end
        if (bus.isb_start) begin auto_isb = (isb_cnt >= dly); isb_cnt++; end
        else begin auto_isb = 1'b0; isb_cnt = 0; end
        if (bus.imc_start) begin auto_imc = (imc_cnt >= dly); imc_cnt++; end
        else begin auto_imc = 1'b0; imc_cnt = 0; end
      end
      // A start that was waiting for done last cycle must still be high.
      if (ark_pend && !bus.ark_start) hold_err++;
      if (isb_pend && !bus.isb_start) hold_err++;
      if (imc_pend && !bus.imc_start) hold_err++;
      ark_pend = bus.ark_start && !auto_ark;
      isb_pend = bus.isb_start && !auto_isb;
      imc_pend = bus.imc_start && !auto_imc;
      if (bus.ark_start && auto_ark) begin
        ark_seen++;
        if (exp_q.size() == 0) ark_extra++;
        else if (bus.ark_n != exp_q.pop_front()) ark_bad++;
      end
      if (bus.isb_start && auto_isb) isb_seen++;
      if (bus.imc_start && auto_imc) imc_seen++;
      e_sel = MEM_SEL_NONE; e_ark = 1'b0; e_isb = 1'b0; e_imc = 1'b0;
      case (bus.dbg_state)
        ST_ARK_INIT, ST_ARK: begin e_sel = MEM_SEL_ARK; e_ark = 1'b1; end
        ST_ISB:              begin e_sel = MEM_SEL_ISB; e_isb = 1'b1; end
        ST_IMC:              begin e_sel = MEM_SEL_IMC; e_imc = 1'b1; end
        ST_IDLE, ST_DONE:    ;
        default:             cyc_err++;
      endcase
      if (bus.mem_sel != e_sel || bus.ark_start != e_ark ||
          bus.isb_start != e_isb || bus.imc_start != e_imc) cyc_err++;
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0] nb;
    int         dly;
    bit         tie;
    bit         exp_err;
    int         exp_ark;
    int         exp_isb;
    int         exp_imc;
    int         exp_lat;
  } vec_t;

  vec_t vecs[9];

  task automatic run_vec(input int idx, input vec_t v);
    int lat, s_ark, s_isb, s_imc, s_bad, s_extra, s_cyc, s_hold;
    bit got;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    manual = 1'b0; tie_all = v.tie; dly = v.dly;
    s_ark = ark_seen; s_isb = isb_seen; s_imc = imc_seen;
    s_bad = ark_bad; s_extra = ark_extra; s_cyc = cyc_err; s_hold = hold_err;
    if (!v.exp_err) for (int k = int'(v.nb); k >= 0; k--) exp_q.push_back(5'(k));
    bus.nb = v.nb;
    bus.ap_start = 1'b1;
    lat = 0; got = 1'b0;
    for (int c = 0; c < 1000 && !got; c++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) bus.ap_start = 1'b0;
      if (bus.ap_done) got = 1'b1;
    end
    check({tag, "_done_seen"}, int'(got), 1);
    check({tag, "_latency"}, lat, v.exp_lat);
    check({tag, "_ap_ready"}, int'(bus.ap_ready), 1);
    check({tag, "_err"}, int'(bus.err), int'(v.exp_err));
    @(negedge clk);
    check({tag, "_done_1cyc"}, int'(bus.ap_done), 0);
    check({tag, "_idle_after"}, int'(bus.ap_idle), 1);
    check({tag, "_err_hold"}, int'(bus.err), int'(v.exp_err));
    check({tag, "_ark_cnt"}, ark_seen - s_ark, v.exp_ark);
    check({tag, "_isb_cnt"}, isb_seen - s_isb, v.exp_isb);
    check({tag, "_imc_cnt"}, imc_seen - s_imc, v.exp_imc);
    check({tag, "_ark_n_seq"}, ark_bad - s_bad, 0);
    check({tag, "_ark_n_extra"}, ark_extra - s_extra, 0);
    check({tag, "_ark_n_missing"}, exp_q.size(), 0);
    check({tag, "_sel_start_decode"}, cyc_err - s_cyc, 0);
    check({tag, "_start_hold"}, hold_err - s_hold, 0);
    exp_q.delete();
  endtask

  task automatic step_done(input int which);
    case (which)
      0:       man_ark = 1'b1;
      1:       man_isb = 1'b1;
      default: man_imc = 1'b1;
    endcase
    @(negedge clk);
    man_ark = 1'b0; man_isb = 1'b0; man_imc = 1'b0;
  endtask

  initial begin
    int rdly, done_cnt, lat, t1, s_ark, s_isb, s_imc, s_bad;
    bus.ap_start = 1'b0;
    bus.nb = 4'd0;

    rdly = $urandom_range(0, 2);
    vecs[0] = '{4'd10, 0, 1'b1, 1'b0, 11, 10,  9,  31};
    vecs[1] = '{4'd14, 3, 1'b0, 1'b0, 15, 14, 13, 169};
    vecs[2] = '{4'd11, 0, 1'b1, 1'b1,  0,  0,  0,   1};
    vecs[3] = '{4'd12, 0, 1'b1, 1'b0, 13, 12, 11,  37};
    vecs[4] = '{4'd12, 2, 1'b0, 1'b0, 13, 12, 11, 109};
    vecs[5] = '{4'd10, 1, 1'b0, 1'b0, 11, 10,  9,  61};
    vecs[6] = '{4'd0,  0, 1'b0, 1'b1,  0,  0,  0,   1};
    vecs[7] = '{4'd15, 0, 1'b1, 1'b1,  0,  0,  0,   1};
    vecs[8] = '{4'd14, rdly, 1'b0, 1'b0, 15, 14, 13, 3 * 14 * (rdly + 1) + 1};

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("rst_ark_start", int'(bus.ark_start), 0);
    check("rst_isb_start", int'(bus.isb_start), 0);
    check("rst_imc_start", int'(bus.imc_start), 0);
    check("rst_ap_done", int'(bus.ap_done), 0);
    check("rst_ap_ready", int'(bus.ap_ready), 0);
    check("rst_mem_sel", int'(bus.mem_sel), 3);
    check("rst_round", int'(bus.round), 0);
    check("rst_err", int'(bus.err), 0);
    check("rst_ap_idle", int'(bus.ap_idle), 1);
    rst = 1'b0;
    @(negedge clk);

    // ---- table-driven passes ----
    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // ---- stray done ignored, then reset in IMC with r=5 ----
    @(negedge clk);
    manual = 1'b1;
    bus.nb = 4'd10;
    bus.ap_start = 1'b1;
    @(negedge clk);
    bus.ap_start = 1'b0;
    check("hs_init_ark_start", int'(bus.ark_start), 1);
    check("hs_init_ark_n", int'(bus.ark_n), 10);
    check("hs_init_mem_sel", int'(bus.mem_sel), 0);
    step_done(0);
    check("hs_isb_round", int'(bus.round), 9);
    check("hs_isb_mem_sel", int'(bus.mem_sel), 1);
    step_done(2);
    check("ign_state", int'(bus.dbg_state), int'(ST_ISB));
    check("ign_round", int'(bus.round), 9);
    check("ign_mem_sel", int'(bus.mem_sel), 1);
    check("ign_isb_start", int'(bus.isb_start), 1);
    check("ign_imc_start", int'(bus.imc_start), 0);
    for (int i = 0; i < 4; i++) begin
      step_done(1);
      step_done(0);
      step_done(2);
    end
    check("hs_round5", int'(bus.round), 5);
    step_done(1);
    check("hs_ark_n5", int'(bus.ark_n), 5);
    step_done(0);
    check("hs_imc_start", int'(bus.imc_start), 1);
    check("hs_imc_mem_sel", int'(bus.mem_sel), 2);
    check("hs_imc_round", int'(bus.round), 5);
    #2 rst = 1'b1;
    #1;
    check("mrst_state", int'(bus.dbg_state), int'(ST_IDLE));
    check("mrst_round", int'(bus.round), 0);
    check("mrst_starts", int'({bus.ark_start, bus.isb_start, bus.imc_start}), 0);
    check("mrst_mem_sel", int'(bus.mem_sel), 3);
    check("mrst_ap_done", int'(bus.ap_done), 0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.ap_done) done_cnt++;
    end
    check("mrst_no_done", done_cnt, 0);
    check("mrst_idle", int'(bus.ap_idle), 1);

    // ---- back-to-back passes with ap_start held ----
    manual = 1'b0; tie_all = 1'b1; dly = 0;
    s_ark = ark_seen; s_isb = isb_seen; s_imc = imc_seen; s_bad = ark_bad;
    for (int p = 0; p < 2; p++)
      for (int k = 10; k >= 0; k--) exp_q.push_back(5'(k));
    @(negedge clk);
    bus.nb = 4'd10;
    bus.ap_start = 1'b1;
    lat = 0; t1 = 0; done_cnt = 0;
    for (int c = 0; c < 200 && done_cnt < 2; c++) begin
      @(negedge clk);
      lat++;
      if (bus.ap_done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          t1 = lat;
          @(negedge clk);
          lat++;
          check("b2b_done_1cyc", int'(bus.ap_done), 0);
          check("b2b_gap_idle_state", int'(bus.dbg_state), int'(ST_IDLE));
          check("b2b_gap_ap_idle", int'(bus.ap_idle), 0);
        end else begin
          bus.ap_start = 1'b0;
        end
      end
    end
    check("b2b_passes", done_cnt, 2);
    check("b2b_first_lat", t1, 31);
    check("b2b_period", lat - t1, 32);
    @(negedge clk);
    check("b2b_end_done", int'(bus.ap_done), 0);
    check("b2b_end_idle", int'(bus.ap_idle), 1);
    check("b2b_ark_cnt", ark_seen - s_ark, 22);
    check("b2b_isb_cnt", isb_seen - s_isb, 20);
    check("b2b_imc_cnt", imc_seen - s_imc, 18);
    check("b2b_ark_n_seq", ark_bad - s_bad, 0);
    check("b2b_ark_n_missing", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/aes_dec_round_sched.md
AES_DEC_ROUND_SCHED -- requirements
Module: aes_dec_round_sched

Interface
REQ-001 SHALL have parameter NB_W, default 4, the width of the round-count and round-number buses.
REQ-002 SHALL have port ap_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port ap_rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port ap_start, input, 1 bit: level request; sampled only in IDLE.
REQ-005 SHALL have ports ap_done, ap_idle and ap_ready, each an output, 1 bit: HLS-style status.
REQ-006 SHALL have port nb, input, NB_W bits: total round count (10/12/14); sampled with ap_start.
REQ-007 SHALL have port err, output, 1 bit: invalid nb seen on the last start.
REQ-008 SHALL have ports ark_start (output, 1) and ark_done (input, 1): handshake to the AddRoundKey engine.
REQ-009 SHALL have port ark_n, output, 5 bits: round number for AddRoundKey, zero-extended from the counter.
REQ-010 SHALL have ports isb_start (output, 1) and isb_done (input, 1): handshake to the InvShiftRows+InvSubBytes engine.
REQ-011 SHALL have ports imc_start (output, 1) and imc_done (input, 1): handshake to the InvMixColumns engine.
REQ-012 SHALL have port mem_sel, output, 2 bits: owner of the statemt ports (0=ARK, 1=ISB, 2=IMC, 3=none).
REQ-013 SHALL have port round, output, NB_W bits: current value of the round counter r.

Function
REQ-014 SHALL implement a one-hot FSM with states IDLE, ARK_INIT, ISB, ARK, IMC, DONE.
REQ-015 In IDLE with ap_start=1, SHALL capture nb and go to ARK_INIT if nb is 10, 12 or 14, else go to DONE with err set to 1.
REQ-016 In ARK_INIT SHALL drive ark_start=1 and ark_n=nb, and on ark_done SHALL set r to nb-1 and go to ISB.
REQ-017 In ISB SHALL drive isb_start=1, and on isb_done SHALL go to ARK.
REQ-018 In ARK SHALL drive ark_start=1 and ark_n=r, and on ark_done SHALL go to DONE if r=0, else to IMC.
REQ-019 In IMC SHALL drive imc_start=1, and on imc_done SHALL decrement r and go to ISB.
REQ-020 SHALL decode each *_start combinationally from the state, holding it high for every cycle of that state, including the cycle its done is seen.
REQ-021 A done input SHALL be ignored unless the FSM is in the state that owns it; a done arriving in the same cycle as its start SHALL be accepted, giving a 1-cycle state.
REQ-022 SHALL drive mem_sel=0 in ARK_INIT and ARK, 1 in ISB, 2 in IMC, and 3 otherwise.
REQ-023 SHALL hold ap_done and ap_ready high for exactly 1 cycle, in DONE; DONE SHALL always go to IDLE.
REQ-024 SHALL drive ap_idle=1 when in IDLE and ap_start=0.
REQ-025 err SHALL hold until the next accepted ap_start, which clears it to 0.
REQ-026 ap_start held high through DONE SHALL start a new pass from IDLE on the following cycle.
REQ-027 The sequence SHALL comprise nb+1 ARK, nb ISB and nb-1 IMC invocations; with zero-wait done the latency from the sampling cycle to ap_done SHALL be 3*nb+1 cycles.

Reset
REQ-028 ap_rst SHALL force IDLE, r=0, err=0, and the captured nb to 0 asynchronously, at any time.
REQ-029 During reset: all *_start=0, ap_done=0, ap_ready=0, mem_sel=3, round=0.
REQ-030 Reset mid-operation SHALL abandon the pass with no ap_done; after release ap_idle=1 if ap_start=0.

Structure
REQ-031 Package aes_dec_pkg SHALL hold the state encodings, the mem_sel codes and the constants NB_128=10, NB_192=12, NB_256=14.
REQ-032 The round counter (load, decrement, zero flag) SHALL be the single sub-module aes_dec_round_ctr.

Verification
REQ-033 nb=10, all done inputs tied to 1 -> ark_n sequence 10,9,...,0; 10 isb_start cycles; 9 imc_start cycles; ap_done on cycle 31.
REQ-034 nb=14, each done delayed 3 cycles -> 15 ARK, 14 ISB and 13 IMC invocations; *_start held until its done; mem_sel matches the state every cycle.
REQ-035 nb=11 -> DONE next cycle, err=1, no *_start asserted; then nb=12 -> err cleared, 13 ARK invocations.
REQ-036 imc_done pulsed while in ISB -> ignored: state, r and mem_sel are unchanged.
REQ-037 ap_rst asserted while in IMC with r=5 -> immediately IDLE, round=0, all starts=0; no ap_done.
REQ-038 ap_start held high continuously with nb=10 -> back-to-back passes, each with a 1-cycle ap_done, with a 1-cycle gap spent in IDLE between passes.
